// File: rtl/multicycle_control.sv
// Multicycle sequencer for the RV64F core: fetch/decode/execute/FPU wait/mem/writeback, plus instret.
// Optional FPU support compiled in with `define RV64F_FPU_EN.
module multicycle_control #(
  parameter int FPU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] code,
  input  logic [4:0]  funct5,
  input  logic        branch_taken,
  input  logic        mem_ready,
  input  logic        fpu_done,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        ir_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        rf_we,
  output logic        frf_we,
  output logic        fpu_start,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [63:0] instret
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXECUTE   = 4'd2,
    FPU_WAIT  = 4'd3,
    MEM       = 4'd4,
    WRITEBACK = 4'd5,
    TRAP      = 4'd6
  } state_t;

  localparam logic [31:0] BASE_OK = 32'h0B00_7179;
  localparam logic [31:0] FP_OK   = 32'h001F_0202;
  localparam logic [7:0]  TO8     = 8'(FPU_TIMEOUT);

  state_t st;
  logic   onehot, legal, is_mem, is_store, is_fpu, fp_int, fp_write;

  assign state    = st;
  assign onehot   = (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0);
  assign is_mem   = code[0] | code[1] | code[8] | code[9];
  assign is_store = code[8] | code[9];
  assign is_fpu   = |code[20:16];
  assign fp_int   = code[20] && (funct5 == 5'b10100 || funct5 == 5'b11000 || funct5 == 5'b11100);

`ifdef RV64F_FPU_EN
  logic [7:0] cnt;
  assign legal    = onehot && |(code & (BASE_OK | FP_OK));
  assign fp_write = code[1] | (|code[19:16]) | (code[20] & ~fp_int);
`else
  logic unused_fpu;
  assign legal      = onehot && |(code & BASE_OK);
  assign fp_write   = 1'b0;
  assign unused_fpu = ^{fpu_done, fp_int, is_fpu, TO8, FP_OK};
`endif

  always_comb begin
    pc_en     = 1'b0;
    pc_sel    = 2'd0;
    ir_en     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    rf_we     = 1'b0;
    frf_we    = 1'b0;
    fpu_start = 1'b0;
    illegal   = 1'b0;
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ready;
      end
      EXECUTE: begin
        if (code[24]) begin
          pc_en  = 1'b1;
          pc_sel = branch_taken ? 2'd1 : 2'd0;
        end
        if (code[3]) pc_en = 1'b1;
`ifdef RV64F_FPU_EN
        fpu_start = is_fpu;
`endif
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        pc_en    = mem_ready & is_store;
      end
      WRITEBACK: begin
        pc_en  = 1'b1;
        pc_sel = code[27] ? 2'd1 : (code[25] ? 2'd2 : 2'd0);
        frf_we = fp_write;
        rf_we  = ~fp_write;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

  // Every retiring state also loads the PC, so pc_en doubles as the retire strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= FETCH;
      instret <= 64'd0;
`ifdef RV64F_FPU_EN
      cnt     <= 8'd0;
`endif
    end else begin
      if (pc_en) instret <= instret + 64'd1;
      case (st)
        FETCH:   if (mem_ready) st <= DECODE;
        DECODE:  st <= legal ? EXECUTE : TRAP;
        EXECUTE: begin
          if (is_mem)                 st <= MEM;
          else if (code[24] | code[3]) st <= FETCH;
`ifdef RV64F_FPU_EN
          else if (is_fpu) begin
            st  <= FPU_WAIT;
            cnt <= 8'd0;
          end
`endif
          else                        st <= WRITEBACK;
        end
`ifdef RV64F_FPU_EN
        FPU_WAIT: begin
          if (fpu_done) st <= WRITEBACK;
          else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == TO8) st <= TRAP;
          end
        end
`endif
        MEM:       if (mem_ready) st <= is_store ? FETCH : WRITEBACK;
        WRITEBACK: st <= FETCH;
        TRAP:      st <= TRAP;
        default:   st <= TRAP;
      endcase
    end
  end
endmodule
